// File: rtl/xgriscv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xgriscv_defines (package)
// Brief   : Shared M-extension op codes, default widths and mul/div FSM states.
// Rev     : 1.0
// ============================================================================
package xgriscv_defines;

  localparam int c_XLEN_DEFAULT        = 32;
  localparam int c_RFIDX_WIDTH_DEFAULT = 5;

  localparam logic [2:0] c_OP_MUL    = 3'b000;
  localparam logic [2:0] c_OP_MULH   = 3'b001;
  localparam logic [2:0] c_OP_MULHSU = 3'b010;
  localparam logic [2:0] c_OP_MULHU  = 3'b011;
  localparam logic [2:0] c_OP_DIV    = 3'b100;
  localparam logic [2:0] c_OP_DIVU   = 3'b101;
  localparam logic [2:0] c_OP_REM    = 3'b110;
  localparam logic [2:0] c_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/xgriscv_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : xgriscv_muldiv_step
// Brief   : One radix-2 iteration: shift-add multiply or restoring divide.
// Rev     : 1.0
// ============================================================================
module xgriscv_muldiv_step
  import xgriscv_defines::*;
#(
  parameter int XLEN = c_XLEN_DEFAULT
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  always_comb begin
    // Multiply: {hi,lo} is the partial product with the multiplier in lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    w_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    w_shifted = {hi, lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, opnd};
    hi_next   = w_sum[XLEN:1];
    lo_next   = {w_sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      if (!w_diff[XLEN]) begin
        hi_next = w_diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = w_shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xgriscv_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : xgriscv_muldiv
// Brief   : Iterative RV M-extension unit: FSM, iteration counter, sign handling.
// Rev     : 1.0
// ============================================================================
module xgriscv_muldiv
  import xgriscv_defines::*;
#(
  parameter int XLEN        = c_XLEN_DEFAULT,
  parameter int RFIDX_WIDTH = c_RFIDX_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [XLEN-1:0]        srca,
  input  logic [XLEN-1:0]        srcb,
  input  logic [RFIDX_WIDTH-1:0] rdin,
  input  logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [XLEN-1:0]        result,
  output logic [RFIDX_WIDTH-1:0] rdout
);

  localparam int              CNT_W      = $clog2(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]         hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [2:0]              op_q, op_d;
  logic                    neg_q, neg_d;
  logic [RFIDX_WIDTH-1:0]  rd_q, rd_d, rdout_q, rdout_d;

  logic                    w_is_div, w_sa, w_sb, w_a_neg, w_b_neg;
  logic                    w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]         w_a_mag, w_b_mag, w_fast_res;
  logic [XLEN-1:0]         w_hi_nx, w_lo_nx, w_div_val, w_fin;
  logic [2*XLEN-1:0]       w_prod;

  // Operand decode for the request on the inputs
  always_comb begin
    w_is_div = op[2];
    w_sa     = (op == c_OP_MULH) || (op == c_OP_MULHSU) || (op == c_OP_DIV) || (op == c_OP_REM);
    w_sb     = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
    w_a_neg  = w_sa & srca[XLEN-1];
    w_b_neg  = w_sb & srcb[XLEN-1];
    w_a_mag  = w_a_neg ? -srca : srca;
    w_b_mag  = w_b_neg ? -srcb : srcb;
    w_div0   = (srcb == '0);
    w_ovf    = w_sb & (srca == c_SMIN) & (srcb == '1);
    w_fast   = w_is_div & (w_div0 | w_ovf);
    if (w_div0) begin
      w_fast_res = op[1] ? srca : '1;
    end else begin
      w_fast_res = op[1] ? '0 : srca;
    end
  end

  xgriscv_muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div  (op_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .hi_next (w_hi_nx),
    .lo_next (w_lo_nx)
  );

  // Sign fix-up of the final iteration's output
  always_comb begin
    w_prod    = {w_hi_nx, w_lo_nx};
    w_div_val = op_q[1] ? w_hi_nx : w_lo_nx;
    if (neg_q) begin
      w_prod    = -w_prod;
      w_div_val = -w_div_val;
    end
    if (op_q[2]) begin
      w_fin = w_div_val;
    end else if (op_q[1:0] == 2'b00) begin
      w_fin = w_prod[XLEN-1:0];
    end else begin
      w_fin = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rdout_d  = rdout_q;
    case (state_q)
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = w_hi_nx;
          lo_d  = w_lo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_CNT_LAST) begin
            state_d  = ST_DONE;
            result_d = w_fin;
            rdout_d  = rd_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start && !flush) begin
          op_d   = op;
          rd_d   = rdin;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = w_is_div ? w_a_mag : w_b_mag;
          opnd_d = w_is_div ? w_b_mag : w_a_mag;
          // Remainder follows the dividend sign; everything else the sign product
          neg_d  = (w_is_div & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
          if (w_fast) begin
            state_d  = ST_DONE;
            result_d = w_fast_res;
            rdout_d  = rdin;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rdout_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rdout_q  <= rdout_d;
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rdout  = rdout_q;

endmodule
`default_nettype wire

// File: tb/tb_xgriscv_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_xgriscv_muldiv
// Brief   : Self-checking bench for xgriscv_muldiv (XLEN=32) with a result queue.
// Rev     : 1.0
// ============================================================================
module tb_xgriscv_muldiv;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic [4:0]  rdin;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rdout;

  int          n_chk  = 0;
  int          n_fail = 0;
  sb_t         sb_q[$];
  vec_t        vecs[$];
  logic [31:0] last_res;

  xgriscv_muldiv #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .rdin(rdin), .flush(flush), .busy(busy), .done(done), .result(result), .rdout(rdout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub, p;
    logic signed [31:0] s32a, s32b, sq;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    s32a = a;
    s32b = b;
    case (o)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sq = s32a / s32b; return sq;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = s32a % s32b; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called right after a falling edge; the request is accepted at the next rising edge.
  task automatic issue(input vec_t v, input bit push);
    start = 1'b1; op = v.op; srca = v.a; srcb = v.b; rdin = v.rd;
    if (push) sb_q.push_back('{res: v.res, rd: v.rd, lat: v.lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int  cyc = 1;
    int  busy_bad = 0;
    int  lat = sb_q[0].lat;
    sb_t e;
    while (done !== 1'b1 && cyc < 80) begin
      if (busy !== ((lat > 1) && (cyc < lat))) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b0) busy_bad++;
    e = sb_q.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("result", {32'd0, result}, {32'd0, e.res});
    chk("rdout", {59'd0, rdout}, {59'd0, e.rd});
    chk("busy_profile", 64'(busy_bad), 64'd0);
    last_res = e.res;
  endtask

  initial begin
    vec_t v;
    int   seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0; rdin = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", {32'd0, result}, 64'd0);
    chk("reset_rdout", {59'd0, rdout}, 64'd0);

    vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b101, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b111, 32'd5,          32'd0,         5'd12, 32'd5,         1});
    vecs.push_back('{3'b101, 32'd100,        32'd7,         5'd13, 32'd14,        33});
    vecs.push_back('{3'b111, 32'd100,        32'd7,         5'd14, 32'd2,         33});
    vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd15, 32'h4000_0000, 33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'd1,         5'd16, 32'h8000_0000, 33});
    vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'b110, 32'd7,          32'd0,         5'd18, 32'd7,         1});

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1);
      wait_done();
    end

    // done is a single pulse and the result holds afterwards
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("result_hold", {32'd0, result}, {32'd0, last_res});

    for (int i = 0; i < 10; i++) begin
      v.op  = 3'($urandom_range(0, 7));
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      v.rd  = 5'($urandom_range(0, 31));
      v.res = ref_f(v.op, v.a, v.b);
      v.lat = ref_lat(v.op, v.a, v.b);
      issue(v, 1'b1);
      wait_done();
    end

    // Flush at cycle 10 of a DIVU, restart at cycle 11
    @(negedge clk);
    v = '{3'b101, 32'd1000, 32'd3, 5'd20, 32'd333, 33};
    issue(v, 1'b0);
    seen = 0;
    repeat (9) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_result", {32'd0, result}, {32'd0, last_res});
    chk("flush_no_early_done", 64'(seen), 64'd0);
    v = '{3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 33};
    issue(v, 1'b1);
    wait_done();

    // Reset at cycle 5 of a MUL
    @(negedge clk);
    v = '{3'b000, 32'd12, 32'd12, 5'd9, 32'd144, 33};
    issue(v, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_result", {32'd0, result}, 64'd0);
    chk("rst_mid_rdout", {59'd0, rdout}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 64'(seen), 64'd0);

    // flush and start together in IDLE: start dropped
    start = 1'b1; flush = 1'b1; op = 3'b101; srca = 32'd9; srcb = 32'd0; rdin = 5'd30;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    chk("flush_start_done", {63'd0, done}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("flush_start_no_done", 64'(seen), 64'd0);
    chk("flush_start_rdout", {59'd0, rdout}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
